tlp_tx_arbiter: RTL and testbench
=================================

Name: tlp_tx_arbiter

Overview:
Packet-aware N-channel round-robin arbiter merging several FPGA->Host TLP streams onto the single 64-bit tx pipe of the PCIe core wrapper. Lets multiple application engines (DMA, register completer, MSI generator) share one core. Grants whole TLPs, SOP to EOP, never interleaving beats. Output is registered, with full valid/ready throughput.

Parameters:
NUM_CHAN, 4, number of upstream TLP sources (2..8)
DATA_WIDTH, 64, TLP beat width in bits (64 or 128)

Ports:
pcieClk_in  in  1  PCIe core clock; all logic is on this clock
reset_in  in  1  synchronous, active-high reset
chanData_in  in  NUM_CHAN*DATA_WIDTH  per-channel beat data; channel i is bits [i*DATA_WIDTH +: DATA_WIDTH]
chanSOP_in  in  NUM_CHAN  per-channel start of packet
chanEOP_in  in  NUM_CHAN  per-channel end of packet
chanValid_in  in  NUM_CHAN  per-channel beat valid
chanReady_out  out  NUM_CHAN  per-channel beat accepted
txData_out  out  DATA_WIDTH  merged beat data to the core
txSOP_out  out  1  merged start of packet
txEOP_out  out  1  merged end of packet
txValid_out  out  1  merged beat valid
txReady_in  in  1  core ready
curChan_out  out  $clog2(NUM_CHAN)  channel owning the beat in the output register
orphanErr_out  out  1  sticky flag: a beat without SOP arrived while no channel was granted

Behaviour:
- Reset values: txValid_out=0, txSOP_out=0, txEOP_out=0, txData_out=0, curChan_out=0, orphanErr_out=0, state=IDLE, rrPtr=NUM_CHAN-1, so channel 0 has first priority.
- Output stage: one register. advance = !txValid_out || txReady_in. Latency is 1 cycle from input handshake to txValid_out. Sustains one beat per cycle under continuous txReady_in.
- Handshake: a beat on channel i transfers when chanValid_in[i] && chanReady_out[i]. chanReady_out[i] = advance && (i == grant). chanReady_out is 0 for every non-granted channel.
- Output register update: when advance, the register loads the transferred beat. If no beat transfers, txValid_out goes to 0.
- FSM IDLE: search channels rrPtr+1 .. rrPtr+NUM_CHAN, modulo NUM_CHAN. Select the first with chanValid_in && chanSOP_in. The grant is combinational, so the SOP beat transfers in the same cycle. On transfer, rrPtr is set to the granted channel.
  - If the SOP beat also has EOP, stay in IDLE.
  - Otherwise go to PASS and latch lockChan.
- IDLE orphans: any channel that is valid without SOP and is not being granted is accepted and discarded (chanReady_out=1 while advance). This sets orphanErr_out; it clears only on reset.
- FSM PASS: grant=lockChan and all other channels are held. When the beat transferred with EOP, return to IDLE. The next arbitration can occur the following cycle, giving one idle bubble maximum between packets.
- Backpressure: when txReady_in=0 and txValid_out=1, the register holds txData_out, txSOP_out, txEOP_out and curChan_out stable, and all chanReady_out are 0.
- Simultaneous SOPs: exactly one is granted per arbitration. Losers keep their valid asserted with no loss.
- Wrap-around: rrPtr=NUM_CHAN-1 searches from channel 0.
- Reset mid-packet: the packet is abandoned; the output is invalid the next cycle and the FSM is in IDLE. The remainder of the abandoned packet then arrives as orphans and is dropped, setting orphanErr_out.
- The arbiter does not inspect TLP header contents.

Optional Feature:
- Macro: TLP_TX_ARBITER_STATS_EN.
- When defined, the block adds pktCount_out, output, NUM_CHAN*16 bits. It holds a per-channel 16-bit counter of TLPs forwarded, incremented on the EOP beat transfer, wrapping 0xFFFF->0, and reset to 0.
- It also adds dropCount_out, output, 16 bits, which counts orphan beats dropped and saturates at 0xFFFF.
- When undefined, these ports and counters are absent and the remaining behaviour is identical.

Decomposition:
- Package tlp_pkg holds:
  - a typedef for the beat struct (data, sop, eop);
  - constants TLP_BEAT_W=64 and MAX_CHAN=8;
  - a function computing the round-robin next index.
- One sub-module, rr_pick: a combinational round-robin priority picker. Inputs are a request vector and rrPtr; outputs are a one-hot/index grant and a "found" flag. It is reusable by the future rx router.

Test Plan:
- Single packet: ch1 sends a 3-beat TLP (SOP at 0xA0, 0xA1, EOP at 0xA2), txReady_in=1 -> tx shows 0xA0..0xA2 on consecutive cycles, 1 cycle after input, with curChan_out=1.
- Simultaneous SOP: ch0 and ch2 each send a 2-beat TLP after reset -> ch0's packet is output completely, then ch2's, with no interleaving; ch2 is held with valid asserted.
- Fairness: all 4 channels send continuous single-beat TLPs (SOP=EOP=1) for 40 cycles -> grant order is 0,1,2,3 repeating, 10 packets each.
- Backpressure: txReady_in=0 for 5 cycles mid-packet on ch3 -> output is stable, chanReady_out=0, and no beat is lost or duplicated after release.
- Orphan: ch2 drives a valid beat with no SOP while IDLE -> the beat is consumed, nothing appears on tx, and orphanErr_out=1 (dropCount_out=1 with STATS_EN).
- Reset mid-packet: reset_in pulses on the 2nd of 4 beats -> txValid_out=0 the next cycle; a fresh ch0 SOP is granted immediately afterwards.

Source files
------------

// File: rtl/tlp_pkg.sv
// Shared types and helpers for the TLP transmit path: beat payload, channel limits,
// and the round-robin index helper used by the pickers.
package tlp_pkg;

    localparam int unsigned TLP_BEAT_W = 64;
    localparam int unsigned MAX_CHAN   = 8;

    typedef struct packed {
        logic [TLP_BEAT_W-1:0] data;
        logic                  sop;
        logic                  eop;
    } tlp_beat_t;

    // Channel visited at search offset 'off' past the round-robin pointer.
    function automatic int unsigned rr_index(input int unsigned ptr,
                                             input int unsigned off,
                                             input int unsigned n);
        return (ptr + off) % n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request strictly after ptr_i (wrapping),
// returned both as index and one-hot, with a found flag.
module rr_pick
    import tlp_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    logic [IW-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'(rr_index(32'(ptr_i), k, N));
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
        gnt_o = found_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/tlp_tx_arbiter.sv
// Packet-aware round-robin merge of NUM_CHAN TLP streams onto one registered tx pipe.
// Optional per-channel packet / orphan-drop counters under TLP_TX_ARBITER_STATS_EN.
module tlp_tx_arbiter
    import tlp_pkg::*;
#(
    parameter  int unsigned NUM_CHAN   = 4,
    parameter  int unsigned DATA_WIDTH = 64,
    localparam int unsigned CW         = $clog2(NUM_CHAN)
) (
    input  logic                           pcieClk_in,
    input  logic                           reset_in,
    input  logic [NUM_CHAN*DATA_WIDTH-1:0] chanData_in,
    input  logic [NUM_CHAN-1:0]            chanSOP_in,
    input  logic [NUM_CHAN-1:0]            chanEOP_in,
    input  logic [NUM_CHAN-1:0]            chanValid_in,
    output logic [NUM_CHAN-1:0]            chanReady_out,
    output logic [DATA_WIDTH-1:0]          txData_out,
    output logic                           txSOP_out,
    output logic                           txEOP_out,
    output logic                           txValid_out,
    input  logic                           txReady_in,
    output logic [CW-1:0]                  curChan_out,
    output logic                           orphanErr_out
`ifdef TLP_TX_ARBITER_STATS_EN
    ,
    output logic [NUM_CHAN*16-1:0]         pktCount_out,
    output logic [15:0]                    dropCount_out
`endif
);

    typedef enum logic {S_IDLE, S_PASS} state_e;

    state_e                state_q;
    logic [CW-1:0]         rr_ptr_q, lock_q, cur_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q, sop_q, eop_q, orphan_q;

    logic                  advance, found, xfer;
    logic [NUM_CHAN-1:0]   pick_gnt, orphan, ready;
    logic [CW-1:0]         pick_idx, gnt_idx;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  gnt_sop, gnt_eop;

    rr_pick #(.N(NUM_CHAN)) u_pick (
        .req_i   (chanValid_in & chanSOP_in),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .found_o (found)
    );

    // Grant/ready: locked channel while passing a packet, else SOP winner plus orphan sink.
    always_comb begin
        advance = !valid_q || txReady_in;
        gnt_idx = (state_q == S_PASS) ? lock_q : pick_idx;
        orphan  = '0;
        ready   = '0;
        if (advance) begin
            if (state_q == S_PASS) begin
                ready[lock_q] = 1'b1;
            end else begin
                orphan = chanValid_in & ~chanSOP_in;
                ready  = pick_gnt | orphan;
            end
        end
        gnt_data = '0;
        gnt_sop  = 1'b0;
        gnt_eop  = 1'b0;
        for (int i = 0; i < int'(NUM_CHAN); i++) begin
            if (CW'(i) == gnt_idx) begin
                gnt_data = chanData_in[i*DATA_WIDTH +: DATA_WIDTH];
                gnt_sop  = chanSOP_in[i];
                gnt_eop  = chanEOP_in[i];
            end
        end
        xfer = advance && chanValid_in[gnt_idx] && ((state_q == S_PASS) || found);
    end

    always_ff @(posedge pcieClk_in) begin
        if (reset_in) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= CW'(NUM_CHAN - 1);
            lock_q   <= '0;
            cur_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            orphan_q <= 1'b0;
        end else begin
            if (advance) begin
                valid_q <= xfer;
                if (xfer) begin
                    data_q <= gnt_data;
                    sop_q  <= gnt_sop;
                    eop_q  <= gnt_eop;
                    cur_q  <= gnt_idx;
                end
            end
            if (|orphan) orphan_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (xfer) begin
                        rr_ptr_q <= gnt_idx;
                        if (!gnt_eop) begin
                            state_q <= S_PASS;
                            lock_q  <= gnt_idx;
                        end
                    end
                end
                S_PASS: begin
                    if (xfer && gnt_eop) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign chanReady_out = ready;
    assign txData_out    = data_q;
    assign txSOP_out     = sop_q;
    assign txEOP_out     = eop_q;
    assign txValid_out   = valid_q;
    assign curChan_out   = cur_q;
    assign orphanErr_out = orphan_q;

`ifdef TLP_TX_ARBITER_STATS_EN
    logic [15:0] pkt_cnt_q [NUM_CHAN];
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [4:0]  drop_sum;

    // Drop counter saturates; several orphans can be discarded in one cycle.
    always_comb begin
        drop_sum = '0;
        for (int i = 0; i < int'(NUM_CHAN); i++) drop_sum = drop_sum + 5'(orphan[i]);
        drop_cnt_d = ((17'(drop_cnt_q) + 17'(drop_sum)) > 17'h0FFFF)
                   ? 16'hFFFF : (drop_cnt_q + 16'(drop_sum));
    end

    always_ff @(posedge pcieClk_in) begin
        if (reset_in) begin
            for (int i = 0; i < int'(NUM_CHAN); i++) pkt_cnt_q[i] <= '0;
            drop_cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CHAN); i++) begin
                if (xfer && gnt_eop && (gnt_idx == CW'(i))) pkt_cnt_q[i] <= pkt_cnt_q[i] + 16'd1;
            end
            drop_cnt_q <= drop_cnt_d;
        end
    end

    for (genvar g = 0; g < int'(NUM_CHAN); g++) begin : g_pkt
        assign pktCount_out[g*16 +: 16] = pkt_cnt_q[g];
    end
    assign dropCount_out = drop_cnt_q;
`endif

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Directed table-driven bench for tlp_tx_arbiter (4 channels, 64-bit beats),
// plus a fairness sequence; stats ports checked when TLP_TX_ARBITER_STATS_EN is defined.
module tb_tlp_tx_arbiter;

    localparam int unsigned NC = 4;
    localparam int unsigned DW = 64;

    logic             clk;
    logic             reset_in;
    logic [NC*DW-1:0] chanData_in;
    logic [NC-1:0]    chanSOP_in, chanEOP_in, chanValid_in, chanReady_out;
    logic [DW-1:0]    txData_out;
    logic             txSOP_out, txEOP_out, txValid_out, txReady_in;
    logic [1:0]       curChan_out;
    logic             orphanErr_out;
`ifdef TLP_TX_ARBITER_STATS_EN
    logic [NC*16-1:0] pktCount_out;
    logic [15:0]      dropCount_out;
`endif

    tlp_tx_arbiter #(.NUM_CHAN(NC), .DATA_WIDTH(DW)) dut (
        .pcieClk_in    (clk),
        .reset_in      (reset_in),
        .chanData_in   (chanData_in),
        .chanSOP_in    (chanSOP_in),
        .chanEOP_in    (chanEOP_in),
        .chanValid_in  (chanValid_in),
        .chanReady_out (chanReady_out),
        .txData_out    (txData_out),
        .txSOP_out     (txSOP_out),
        .txEOP_out     (txEOP_out),
        .txValid_out   (txValid_out),
        .txReady_in    (txReady_in),
        .curChan_out   (curChan_out),
        .orphanErr_out (orphanErr_out)
`ifdef TLP_TX_ARBITER_STATS_EN
        ,
        .pktCount_out  (pktCount_out),
        .dropCount_out (dropCount_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] v, s, e;
        logic [7:0] tag;
        logic       rdy;
        logic [3:0] xr;
        logic       tv;
        logic [15:0] td;
        logic       ts, te;
        logic [1:0] tc;
        logic       orph;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [3:0] s,
                                input logic [3:0] e, input logic [7:0] tag, input logic rdy,
                                input logic [3:0] xr, input logic tv, input logic [15:0] td,
                                input logic ts, input logic te, input logic [1:0] tc,
                                input logic orph);
        vec_t r;
        r.rst = rst; r.v = v; r.s = s; r.e = e; r.tag = tag; r.rdy = rdy; r.xr = xr;
        r.tv = tv; r.td = td; r.ts = ts; r.te = te; r.tc = tc; r.orph = orph;
        return r;
    endfunction

    // Channel i beat data is {i, tag} so the source is visible on tx.
    task automatic drive(input logic rst, input logic [3:0] v, input logic [3:0] s,
                         input logic [3:0] e, input logic [7:0] tag, input logic rdy);
        reset_in     = rst;
        chanValid_in = v;
        chanSOP_in   = s;
        chanEOP_in   = e;
        txReady_in   = rdy;
        for (int i = 0; i < int'(NC); i++)
            chanData_in[i*DW +: DW] = (64'(i) << 8) | 64'(tag);
    endtask

    vec_t tbl [24];
    int   cnt [NC];

    initial begin
        // Single 3-beat packet on ch1
        tbl[0]  = mk(0, 4'b0010, 4'b0010, 4'b0000, 8'hA0, 1, 4'b0010, 1, 16'h01A0, 1, 0, 1, 0);
        tbl[1]  = mk(0, 4'b0010, 4'b0000, 4'b0000, 8'hA1, 1, 4'b0010, 1, 16'h01A1, 0, 0, 1, 0);
        tbl[2]  = mk(0, 4'b0010, 4'b0000, 4'b0010, 8'hA2, 1, 4'b0010, 1, 16'h01A2, 0, 1, 1, 0);
        tbl[3]  = mk(0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 16'h0000, 0, 0, 0, 0);
        // Reset, then simultaneous SOP on ch0 and ch2
        tbl[4]  = mk(1, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 16'h0000, 0, 0, 0, 0);
        tbl[5]  = mk(0, 4'b0101, 4'b0101, 4'b0000, 8'hB0, 1, 4'b0001, 1, 16'h00B0, 1, 0, 0, 0);
        tbl[6]  = mk(0, 4'b0101, 4'b0100, 4'b0001, 8'hB1, 1, 4'b0001, 1, 16'h00B1, 0, 1, 0, 0);
        tbl[7]  = mk(0, 4'b0100, 4'b0100, 4'b0000, 8'hB2, 1, 4'b0100, 1, 16'h02B2, 1, 0, 2, 0);
        tbl[8]  = mk(0, 4'b0100, 4'b0000, 4'b0100, 8'hB3, 1, 4'b0100, 1, 16'h02B3, 0, 1, 2, 0);
        // Backpressure for 5 cycles mid-packet on ch3
        tbl[9]  = mk(0, 4'b1000, 4'b1000, 4'b0000, 8'hC0, 1, 4'b1000, 1, 16'h03C0, 1, 0, 3, 0);
        for (int k = 10; k <= 14; k++)
            tbl[k] = mk(0, 4'b1000, 4'b0000, 4'b0000, 8'hC1, 0, 4'b0000, 1, 16'h03C0, 1, 0, 3, 0);
        tbl[15] = mk(0, 4'b1000, 4'b0000, 4'b0000, 8'hC1, 1, 4'b1000, 1, 16'h03C1, 0, 0, 3, 0);
        tbl[16] = mk(0, 4'b1000, 4'b0000, 4'b1000, 8'hC2, 1, 4'b1000, 1, 16'h03C2, 0, 1, 3, 0);
        tbl[17] = mk(0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 16'h0000, 0, 0, 0, 0);
        // Orphans: alone, then alongside a granted single-beat packet
        tbl[18] = mk(0, 4'b0100, 4'b0000, 4'b0000, 8'hD0, 1, 4'b0100, 0, 16'h0000, 0, 0, 0, 1);
        tbl[19] = mk(0, 4'b0101, 4'b0001, 4'b0001, 8'hE0, 1, 4'b0101, 1, 16'h00E0, 1, 1, 0, 1);
        // Reset on the second beat, remainder dropped, fresh SOP granted
        tbl[20] = mk(0, 4'b0001, 4'b0001, 4'b0000, 8'hF0, 1, 4'b0001, 1, 16'h00F0, 1, 0, 0, 1);
        tbl[21] = mk(1, 4'b0001, 4'b0000, 4'b0000, 8'hF1, 1, 4'b0001, 0, 16'h0000, 0, 0, 0, 0);
        tbl[22] = mk(0, 4'b0001, 4'b0000, 4'b0000, 8'hF2, 1, 4'b0001, 0, 16'h0000, 0, 0, 0, 1);
        tbl[23] = mk(0, 4'b0001, 4'b0001, 4'b0001, 8'hF3, 1, 4'b0001, 1, 16'h00F3, 1, 1, 0, 1);

        drive(1, 4'b0, 4'b0, 4'b0, 8'h00, 1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(txValid_out), 64'd0);
        check("rst_sop", 64'(txSOP_out), 64'd0);
        check("rst_eop", 64'(txEOP_out), 64'd0);
        check("rst_data", txData_out, 64'd0);
        check("rst_chan", 64'(curChan_out), 64'd0);
        check("rst_orph", 64'(orphanErr_out), 64'd0);

        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            drive(tbl[k].rst, tbl[k].v, tbl[k].s, tbl[k].e, tbl[k].tag, tbl[k].rdy);
            #1;
            check($sformatf("v%0d_ready", k), 64'(chanReady_out), 64'(tbl[k].xr));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", k), 64'(txValid_out), 64'(tbl[k].tv));
            check($sformatf("v%0d_orph", k), 64'(orphanErr_out), 64'(tbl[k].orph));
            if (tbl[k].tv) begin
                check($sformatf("v%0d_data", k), txData_out, 64'(tbl[k].td));
                check($sformatf("v%0d_sop", k), 64'(txSOP_out), 64'(tbl[k].ts));
                check($sformatf("v%0d_eop", k), 64'(txEOP_out), 64'(tbl[k].te));
                check($sformatf("v%0d_chan", k), 64'(curChan_out), 64'(tbl[k].tc));
            end
        end

`ifdef TLP_TX_ARBITER_STATS_EN
        check("stats_drop", 64'(dropCount_out), 64'd1);
        check("stats_pkt0", 64'(pktCount_out[15:0]), 64'd1);
`endif

        // Fairness: all channels offer back-to-back single-beat packets
        @(negedge clk);
        drive(1, 4'b0, 4'b0, 4'b0, 8'h00, 1);
        @(negedge clk);
        for (int i = 0; i < int'(NC); i++) cnt[i] = 0;
        for (int c = 0; c < 40; c++) begin
            drive(0, 4'b1111, 4'b1111, 4'b1111, 8'(c), 1);
            #1;
            check($sformatf("fair%0d_ready", c), 64'(chanReady_out), 64'(4'b0001 << (c % 4)));
            @(posedge clk);
            #1;
            check($sformatf("fair%0d_valid", c), 64'(txValid_out), 64'd1);
            check($sformatf("fair%0d_chan", c), 64'(curChan_out), 64'(c % 4));
            check($sformatf("fair%0d_data", c), txData_out, (64'(c % 4) << 8) | 64'(c));
            if (txValid_out) cnt[curChan_out]++;
            @(negedge clk);
        end
        for (int i = 0; i < int'(NC); i++)
            check($sformatf("fair_count%0d", i), 64'(cnt[i]), 64'd10);
`ifdef TLP_TX_ARBITER_STATS_EN
        for (int i = 0; i < int'(NC); i++)
            check($sformatf("stats_fair_pkt%0d", i), 64'(pktCount_out[i*16 +: 16]), 64'd10);
        check("stats_fair_drop", 64'(dropCount_out), 64'd0);
`endif
        drive(0, 4'b0, 4'b0, 4'b0, 8'h00, 1);
        @(posedge clk);
        #1;
        check("drain_valid", 64'(txValid_out), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
